// File: rtl/opc5ls_uart.sv
// Memory-mapped UART for the OPC5LS CPU: DATA register at BASE_ADDR, STATUS at BASE_ADDR+1.
// The 4-deep TX FIFO and transmitter are always present; define OPC5LS_UART_RX_EN to build the receiver.
module opc5ls_uart #(
  parameter logic [15:0] BASE_ADDR = 16'hFE08,
  parameter logic [15:0] CLK_DIV   = 16'd434
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [15:0] address,
  input  logic [15:0] din,
  input  logic        rnw,
  output logic [15:0] dout,
  output logic        sel,
  output logic        txd,
  input  logic        rxd
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic       data_sel, wr_data, rd_data, push, pop;
  logic       tx_full, tx_empty;
  logic [7:0] rx_data;
  logic       rx_valid, rx_overrun, frame_err;

  assign sel      = (address[15:1] == BASE_ADDR[15:1]);
  assign data_sel = sel & ~address[0];
  assign wr_data  = data_sel & ~rnw;
  assign rd_data  = data_sel & rnw;

  always_comb begin
    dout = 16'h0000;
    if (sel && rnw)
      dout = address[0] ? {11'b0, frame_err, rx_overrun, rx_valid, tx_empty, tx_full}
                        : {8'h00, rx_data};
  end

  // ---------------- TX FIFO ----------------
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  state_t     tx_state, tx_state_n;

  assign push     = wr_data && (count != 3'd4);
  assign pop      = (tx_state == IDLE) && (count != 3'd0);
  assign tx_full  = (count == 3'd4);
  assign tx_empty = (count == 3'd0) && (tx_state == IDLE);

  // NOTE: storage arrays carry no reset; the reset pointers and count make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= din[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- Transmitter ----------------
  logic [15:0] tx_div, tx_div_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        txd_n, tx_last;

  assign tx_last = (tx_div == CLK_DIV - 16'd1);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    tx_state_n = tx_state;
    tx_div_n   = tx_div + 16'd1;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    txd_n      = 1'b1;
    case (tx_state)
      IDLE: begin
        tx_div_n = 16'd0;
        if (pop) begin
          tx_state_n = START;
          tx_shift_n = fifo_mem[rd_ptr];
        end
      end
      START: if (tx_last) begin
        tx_div_n   = 16'd0;
        tx_bit_n   = 3'd0;
        tx_state_n = DATA;
      end
      DATA: if (tx_last) begin
        tx_div_n = 16'd0;
        if (tx_bit == 3'd7) tx_state_n = STOP;
        else begin
          tx_bit_n   = tx_bit + 3'd1;
          tx_shift_n = {1'b0, tx_shift[7:1]};
        end
      end
      STOP: if (tx_last) begin
        tx_div_n   = 16'd0;
        tx_state_n = IDLE;
      end
      default: tx_state_n = IDLE;
    endcase
    // txd is registered from the next state so the serial line never glitches.
    case (tx_state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = tx_shift_n[0];
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      tx_state <= IDLE;
      tx_div   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_div   <= tx_div_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txd      <= txd_n;
    end
  end

`ifdef OPC5LS_UART_RX_EN
  // ---------------- Receiver ----------------
  logic        rxd_m, rxd_s;
  state_t      rx_state, rx_state_n;
  logic [15:0] rx_div, rx_div_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_done_ok, rx_done_bad, rx_last;
  logic        unused_bits;

  assign unused_bits = ^din[15:8];
  assign rx_last     = (rx_div == CLK_DIV - 16'd1);

  always_comb begin
    rx_state_n  = rx_state;
    rx_div_n    = rx_div + 16'd1;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    rx_done_ok  = 1'b0;
    rx_done_bad = 1'b0;
    case (rx_state)
      IDLE: begin
        rx_div_n = 16'd0;
        if (!rxd_s) rx_state_n = START;
      end
      START: if (rx_div == (CLK_DIV >> 1) - 16'd1) begin
        rx_div_n   = 16'd0;
        rx_bit_n   = 3'd0;
        rx_state_n = rxd_s ? IDLE : DATA;
      end
      DATA: if (rx_last) begin
        rx_div_n   = 16'd0;
        rx_shift_n = {rxd_s, rx_shift[7:1]};
        if (rx_bit == 3'd7) rx_state_n = STOP;
        else                rx_bit_n   = rx_bit + 3'd1;
      end
      STOP: if (rx_last) begin
        rx_div_n    = 16'd0;
        rx_state_n  = IDLE;
        rx_done_ok  = rxd_s;
        rx_done_bad = ~rxd_s;
      end
      default: rx_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rxd_m      <= 1'b1;
      rxd_s      <= 1'b1;
      rx_state   <= IDLE;
      rx_div     <= 16'd0;
      rx_bit     <= 3'd0;
      rx_shift   <= 8'h00;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rxd_m    <= rxd;
      rxd_s    <= rxd_m;
      rx_state <= rx_state_n;
      rx_div   <= rx_div_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      if (rd_data) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
        frame_err  <= 1'b0;
      end
      // A completing byte overrides a same-edge read; overrun only if the old byte was never read.
      if (rx_done_ok) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
        if (rx_valid && !rd_data) rx_overrun <= 1'b1;
      end
      if (rx_done_bad) frame_err <= 1'b1;
    end
  end
`else
  logic unused_bits;

  assign unused_bits = ^{din[15:8], rxd};
  assign rx_data     = 8'h00;
  assign rx_valid    = 1'b0;
  assign rx_overrun  = 1'b0;
  assign frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_opc5ls_uart.sv
// Self-checking bench for opc5ls_uart (CLK_DIV=4): a serial-line monitor decodes txd frames and
// compares them against a queue of expected bytes filled by the stimulus; register reads are checked inline.
module tb_opc5ls_uart;

  localparam int          CLK_DIV   = 4;
  localparam logic [15:0] DATA_ADDR = 16'hFE08;
  localparam logic [15:0] STAT_ADDR = 16'hFE09;
  localparam logic [15:0] IDLE_ADDR = 16'h0000;

  logic        clk     = 1'b0;
  logic        reset_b = 1'b0;
  logic [15:0] address = IDLE_ADDR;
  logic [15:0] din     = 16'h0000;
  logic        rnw     = 1'b1;
  logic        rxd     = 1'b1;
  logic [15:0] dout;
  logic        sel, txd;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];

  opc5ls_uart #(.BASE_ADDR(16'hFE08), .CLK_DIV(16'd4)) dut (
    .clk(clk), .reset_b(reset_b), .address(address), .din(din), .rnw(rnw),
    .dout(dout), .sel(sel), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus tasks drive on the falling edge; a write stays asserted until the next bus call so writes can run back-to-back.
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a; din = d; rnw = 1'b0;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    address = IDLE_ADDR; din = 16'h0000; rnw = 1'b1;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    address = a; din = 16'h0000; rnw = 1'b1;
    #1 d = dout;
    @(negedge clk);
    address = IDLE_ADDR;
  endtask

  task automatic read_expect(input logic [15:0] a, input logic [15:0] exp, input string name);
    logic [15:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_idle();
    logic [15:0] s;
    s = 16'h0000;
    for (int i = 0; i < 400 && s !== 16'h0002; i++) bus_read(STAT_ADDR, s);
    check("wait_idle_status", s, 16'h0002);
    check("tx_queue_drained", 16'(exp_q.size()), 16'd0);
  endtask

  // From an idle transmitter the first byte is popped one edge after it lands, so a
  // back-to-back burst can place five bytes (one in flight plus four queued); later ones are dropped.
  task automatic send_burst(input int n);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom());
      if (i < 5) exp_q.push_back(w[7:0]);
      bus_write(DATA_ADDR, w);
    end
    bus_idle();
  endtask

  // Serial monitor: detects a start edge, samples mid-bit, pops the expected byte at the stop bit.
  task automatic decode_frame();
    logic [9:0] fr;
    logic [7:0] e;
    bit         aborted;
    aborted = 1'b0;
    repeat (CLK_DIV / 2) begin @(negedge clk); if (!reset_b) aborted = 1'b1; end
    fr[0] = txd;
    for (int b = 1; b < 10; b++) begin
      repeat (CLK_DIV) begin @(negedge clk); if (!reset_b) aborted = 1'b1; end
      fr[b] = txd;
    end
    if (!aborted) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tx_unexpected_frame: got frame %b expected no transmission", fr);
      end else begin
        e = exp_q.pop_front();
        check("tx_frame", 16'(fr), 16'({1'b1, e, 1'b0}));
      end
    end
  endtask

  initial begin : monitor
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_b && prev && !txd) decode_frame();
      prev = txd;
    end
  end

`ifdef OPC5LS_UART_RX_EN
  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxd = fr[i];
      repeat (CLK_DIV - 1) @(negedge clk);
    end
    @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask
`endif

  initial begin : stimulus
    logic [39:0] wave;
    logic [9:0]  fr;
    int          n;
`ifdef OPC5LS_UART_RX_EN
    logic [7:0]  rb;
    logic [7:0]  last_rx;
`endif

    // Reset state, observed while reset_b is still low.
    repeat (3) @(negedge clk);
    address = STAT_ADDR;
    #1 check("reset_txd", 16'(txd), 16'd1);
    check("reset_status", dout, 16'h0002);
    address = IDLE_ADDR;
    @(negedge clk);
    reset_b = 1'b1;
    read_expect(STAT_ADDR, 16'h0002, "status_after_reset");

    // Address decode and the unmapped read value.
    @(negedge clk);
    address = DATA_ADDR;  #1 check("sel_data", 16'(sel), 16'd1);
    address = STAT_ADDR;  #1 check("sel_status", 16'(sel), 16'd1);
    address = 16'hFE0A;   #1 check("sel_other", 16'(sel), 16'd0);
    check("dout_unselected", dout, 16'h0000);
    address = IDLE_ADDR;

    // A write to STATUS must not queue anything.
    bus_write(STAT_ADDR, 16'h00AA);
    bus_idle();
    repeat (3) @(negedge clk);
    read_expect(STAT_ADDR, 16'h0002, "status_write_ignored");

    // Exact waveform for one byte; the high byte of the write is ignored.
    exp_q.push_back(8'h55);
    bus_write(DATA_ADDR, 16'h1255);
    bus_idle();
    check("txd_before_start", 16'(txd), 16'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      wave[i] = txd;
    end
    fr = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10; k++)
      check($sformatf("wave_bit%0d", k), 16'(wave[4*k +: 4]), 16'({4{fr[k]}}));
    read_expect(STAT_ADDR, 16'h0002, "status_after_frame");

    // Six back-to-back writes: full after the fifth, sixth dropped.
    for (int v = 1; v <= 5; v++) begin
      exp_q.push_back(8'(v));
      bus_write(DATA_ADDR, 16'(v));
    end
    read_expect(STAT_ADDR, 16'h0001, "status_full_after_5");
    bus_write(DATA_ADDR, 16'h0006);
    bus_idle();
    read_expect(STAT_ADDR, 16'h0001, "status_full_after_6");
    wait_idle();

    // Random bursts of random bytes.
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, 7));
      send_burst(n);
      read_expect(STAT_ADDR, (n >= 5) ? 16'h0001 : 16'h0000, $sformatf("burst%0d_status_n%0d", it, n));
      wait_idle();
    end

`ifdef OPC5LS_UART_RX_EN
    rx_frame(8'hA5, 1'b1);
    read_expect(STAT_ADDR, 16'h0006, "rx_status_valid");
    read_expect(DATA_ADDR, 16'h00A5, "rx_data_a5");
    read_expect(STAT_ADDR, 16'h0002, "rx_status_cleared");

    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    read_expect(STAT_ADDR, 16'h000E, "rx_status_overrun");
    read_expect(DATA_ADDR, 16'h0022, "rx_data_newest");
    read_expect(STAT_ADDR, 16'h0002, "rx_overrun_cleared");
    last_rx = 8'h22;

    @(negedge clk) rxd = 1'b0;
    @(negedge clk) rxd = 1'b1;
    repeat (20) @(negedge clk);
    read_expect(STAT_ADDR, 16'h0002, "rx_glitch_rejected");

    rx_frame(8'h3C, 1'b0);
    read_expect(STAT_ADDR, 16'h0012, "rx_frame_err");
    read_expect(DATA_ADDR, 16'(last_rx), "rx_data_kept");
    read_expect(STAT_ADDR, 16'h0002, "rx_frame_err_cleared");

    for (int it = 0; it < 3; it++) begin
      rb = 8'($urandom());
      rx_frame(rb, 1'b1);
      read_expect(STAT_ADDR, 16'h0006, $sformatf("rx_rand%0d_status", it));
      read_expect(DATA_ADDR, 16'(rb), $sformatf("rx_rand%0d_data", it));
    end
`endif

    // Reset in the middle of a byte with three queued: everything is discarded.
    send_burst(3);
    repeat (10) @(negedge clk);
    #2 reset_b = 1'b0;
    #1 check("txd_in_reset", 16'(txd), 16'd1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    read_expect(STAT_ADDR, 16'h0002, "status_after_mid_reset");
    repeat (150) @(negedge clk);
    check("txd_quiet_after_reset", 16'(txd), 16'd1);
    read_expect(STAT_ADDR, 16'h0002, "status_quiet_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
